// File: rtl/uart_rx_deser.sv
// -----------------------------------------------------------------------------
// uart_rx_deser
//
// Receives 8N1 serial bytes (idle high, LSB first) and presents each one
// through a single-entry output buffer with a valid/ready handshake.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (4..65535)
//
// Ports
//   i_clk        sole clock, rising edge
//   i_rst        synchronous active-high reset
//   i_uart_rx    asynchronous serial input line
//   o_data       received byte, meaningful while o_valid is high
//   o_valid      byte available, held until accepted
//   i_ready      downstream accepts the byte when o_valid && i_ready
//   o_frame_err  one-cycle pulse: stop bit sampled low
//   o_overrun    one-cycle pulse: byte completed while the buffer was full
//   o_busy       high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_deser #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    // Terminal counts: mid-start-bit and full bit period.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cyc_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;

    logic             rx_meta;
    logic             rx_sync;
    logic [1:0]       sync_fill;
    logic             armed;

    // -------------------------------------------------------------------------
    // Two-flop synchronizer. sync_fill marks when rx_sync carries a real line
    // sample rather than the reset value, so the receiver can insist on seeing
    // the line high before accepting a start bit after reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            sync_fill <= 2'b00;
        end else begin
            rx_meta   <= i_uart_rx;
            rx_sync   <= rx_meta;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    // -------------------------------------------------------------------------
    // Receive FSM and output buffer
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            cyc_cnt     <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            armed       <= 1'b0;
            o_data      <= 8'h00;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;

            // NOTE: a later non-blocking assignment in this block overrides
            // this one, so a byte completing in the acceptance cycle keeps
            // o_valid high with the new data loaded.
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!armed) begin
                        // After reset, wait for a genuine high line so a frame
                        // aborted by reset is never picked up mid-stream.
                        if (sync_fill[1] && rx_sync) begin
                            armed <= 1'b1;
                        end
                    end else if (!rx_sync) begin
                        state   <= ST_START;
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        o_busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (cyc_cnt == CNT_HALF) begin
                        cyc_cnt <= '0;
                        if (!rx_sync) begin
                            state <= ST_DATA;
                        end else begin
                            // Line came back high: treat as a glitch.
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (cyc_cnt == CNT_LAST) begin
                        cyc_cnt   <= '0;
                        shift_reg <= {rx_sync, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (cyc_cnt == CNT_LAST) begin
                        cyc_cnt <= '0;
                        if (rx_sync) begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                            if (!o_valid || i_ready) begin
                                o_data  <= shift_reg;
                                o_valid <= 1'b1;
                            end else begin
                                o_overrun <= 1'b1;
                            end
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= ST_BREAK;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                ST_BREAK: begin
                    if (rx_sync) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deser
//
// Directed bench for uart_rx_deser at CLKS_PER_BIT = 16. Inputs are driven
// 2 time units after the rising edge; a monitor on the falling edge counts
// o_valid / o_frame_err / o_overrun cycles and records accepted bytes.
// -----------------------------------------------------------------------------
module tb_uart_rx_deser;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int         valid_cycles = 0;
    int         fe_cycles    = 0;
    int         ov_cycles    = 0;
    logic [7:0] acc_q[$];

    always #5 clk = ~clk;

    uart_rx_deser #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_uart_rx   (rx),
        .o_data      (data),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_frame_err (frame_err),
        .o_overrun   (overrun),
        .o_busy      (busy)
    );

    // Passive monitor: what is seen here is what the next rising edge uses.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid)          valid_cycles++;
            if (frame_err)      fe_cycles++;
            if (overrun)        ov_cycles++;
            if (valid && ready) acc_q.push_back(data);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_bit);
    endtask

    function automatic logic [7:0] acc_at(input int idx);
        if (idx < acc_q.size()) return acc_q[idx];
        return 8'hxx;
    endfunction

    // -------------------------------------------------------------------------
    task automatic test_reset;
        rst   = 1'b1;
        rx    = 1'b1;
        ready = 1'b0;
        tick(5);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %0b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        rst = 1'b0;
        tick(10);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_single_byte;
        int v0, f0, o0, q0;
        ready = 1'b1;
        v0 = valid_cycles; f0 = fe_cycles; o0 = ov_cycles; q0 = acc_q.size();
        send_frame(8'hA5, 1'b1);
        tick(20);
        checks++; if (valid_cycles - v0 !== 1) begin errors++; $display("FAIL single_valid_cycles: got %0d expected 1", valid_cycles - v0); end
        checks++; if (acc_q.size() - q0 !== 1) begin errors++; $display("FAIL single_accept_count: got %0d expected 1", acc_q.size() - q0); end
        checks++; if (acc_at(q0) !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h expected a5", acc_at(q0)); end
        checks++; if (fe_cycles - f0 !== 0) begin errors++; $display("FAIL single_frame_err: got %0d expected 0", fe_cycles - f0); end
        checks++; if (ov_cycles - o0 !== 0) begin errors++; $display("FAIL single_overrun: got %0d expected 0", ov_cycles - o0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %0b expected 0", busy); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_glitch;
        int v0, f0, o0;
        v0 = valid_cycles; f0 = fe_cycles; o0 = ov_cycles;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(1);
        // Receiver is in the start-bit half period at this point.
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_during: got %0b expected 1", busy); end
        tick(20);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_after: got %0b expected 0", busy); end
        checks++; if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", valid_cycles - v0); end
        checks++; if ((fe_cycles - f0) + (ov_cycles - o0) !== 0) begin errors++; $display("FAIL glitch_flags: got %0d expected 0", (fe_cycles - f0) + (ov_cycles - o0)); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_frame_error;
        int v0, f0, q0;
        v0 = valid_cycles; f0 = fe_cycles; q0 = acc_q.size();
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        tick(100);
        checks++; if (fe_cycles - f0 !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cycles - f0); end
        checks++; if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL ferr_valid: got %0d expected 0", valid_cycles - v0); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_break: got %0b expected 1", busy); end
        rx = 1'b1;
        tick(20);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %0b expected 0", busy); end
        send_frame(8'h55, 1'b1);
        tick(20);
        checks++; if (acc_at(q0) !== 8'h55) begin errors++; $display("FAIL ferr_next_data: got %0h expected 55", acc_at(q0)); end
        checks++; if (fe_cycles - f0 !== 1) begin errors++; $display("FAIL ferr_pulses_total: got %0d expected 1", fe_cycles - f0); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_overrun;
        int o0, q0;
        ready = 1'b0;
        tick(1);
        o0 = ov_cycles; q0 = acc_q.size();
        send_frame(8'h11, 1'b1);
        tick(20);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_first: got %0b expected 1", valid); end
        checks++; if (data !== 8'h11) begin errors++; $display("FAIL ovr_data_first: got %0h expected 11", data); end
        send_frame(8'h22, 1'b1);
        tick(20);
        checks++; if (data !== 8'h11) begin errors++; $display("FAIL ovr_data_held: got %0h expected 11", data); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %0b expected 1", valid); end
        checks++; if (ov_cycles - o0 !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", ov_cycles - o0); end
        ready = 1'b1;
        tick(1);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_after_accept: got %0b expected 0", valid); end
        checks++; if (acc_q.size() - q0 !== 1) begin errors++; $display("FAIL ovr_accept_count: got %0d expected 1", acc_q.size() - q0); end
        checks++; if (acc_at(q0) !== 8'h11) begin errors++; $display("FAIL ovr_accept_data: got %0h expected 11", acc_at(q0)); end
        tick(10);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_back_to_back;
        int f0, o0, q0;
        ready = 1'b1;
        f0 = fe_cycles; o0 = ov_cycles; q0 = acc_q.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(20);
        checks++; if (acc_q.size() - q0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", acc_q.size() - q0); end
        checks++; if (acc_at(q0) !== 8'h00) begin errors++; $display("FAIL b2b_first: got %0h expected 00", acc_at(q0)); end
        checks++; if (acc_at(q0 + 1) !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %0h expected ff", acc_at(q0 + 1)); end
        checks++; if ((fe_cycles - f0) + (ov_cycles - o0) !== 0) begin errors++; $display("FAIL b2b_flags: got %0d expected 0", (fe_cycles - f0) + (ov_cycles - o0)); end
    endtask

    // -------------------------------------------------------------------------
    // 0x81 LSB first: data bits 1,0,0,0,0,0,0,1. Reset lands inside bit 2.
    task automatic test_reset_midframe;
        int v0, f0, o0, q0;
        ready = 1'b1;
        v0 = valid_cycles; f0 = fe_cycles; o0 = ov_cycles; q0 = acc_q.size();
        send_bit(1'b0);          // start
        send_bit(1'b1);          // bit 0
        send_bit(1'b0);          // bit 1
        rx = 1'b0;               // bit 2, split around the reset pulse
        tick(5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %0b expected 1", busy); end
        rst = 1'b1;
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b expected 0", valid); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %0h expected 00", data); end
        tick(9);
        rst = 1'b0;
        tick(1);
        for (int i = 3; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);          // bit 7
        send_bit(1'b1);          // stop
        tick(20);
        checks++; if (valid_cycles - v0 !== 0) begin errors++; $display("FAIL rstmid_no_valid: got %0d expected 0", valid_cycles - v0); end
        checks++; if ((fe_cycles - f0) + (ov_cycles - o0) !== 0) begin errors++; $display("FAIL rstmid_flags: got %0d expected 0", (fe_cycles - f0) + (ov_cycles - o0)); end
        send_frame(8'h7E, 1'b1);
        tick(20);
        checks++; if (acc_q.size() - q0 !== 1) begin errors++; $display("FAIL rstmid_next_count: got %0d expected 1", acc_q.size() - q0); end
        checks++; if (acc_at(q0) !== 8'h7E) begin errors++; $display("FAIL rstmid_next_data: got %0h expected 7e", acc_at(q0)); end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        rst   = 1'b1;
        rx    = 1'b1;
        ready = 1'b0;
        tick(1);
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_deser.md
UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 i_clk  input  1  sole clock; all logic on rising edge.
REQ-003 i_rst  input  1  reset is synchronous and active-high.
REQ-004 i_uart_rx  input  1  asynchronous serial line from PC, 8N1, idle high, LSB first.
REQ-005 o_data  output  8  received byte; valid only while o_valid=1.
REQ-006 o_valid  output  1  byte available; held until accepted.
REQ-007 i_ready  input  1  downstream (sender) accepts byte when o_valid&&i_ready on a clock edge.
REQ-008 o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 o_overrun  output  1  one-cycle pulse: byte completed while output buffer still full.
REQ-010 o_busy  output  1  high whenever FSM is not IDLE.

Function
REQ-011 i_uart_rx SHALL pass through a 2-flop synchronizer, reset value 1; all decisions use the synchronized bit only.
REQ-012 FSM states: IDLE, START, DATA, STOP, BREAK; encoding free.
REQ-013 IDLE: synchronized line sampled 0 -> START, bit counter cleared, cycle counter cleared.
REQ-014 START: after floor(CLKS_PER_BIT/2) cycles, resample; 0 -> DATA with cycle counter cleared; 1 -> IDLE (glitch rejected, no flag).
REQ-015 DATA: every CLKS_PER_BIT cycles sample one bit into shift register, LSB first; after 8th sample -> STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles sample; 1 -> byte complete, -> IDLE; 0 -> o_frame_err pulse, byte discarded, -> BREAK.
REQ-017 BREAK: remain until synchronized line is 1, then -> IDLE; no further frame_err pulses during a held-low line.
REQ-018 Cycle counter width SHALL be ceil(log2(CLKS_PER_BIT)); counter SHALL never wrap past CLKS_PER_BIT-1.
REQ-019 Byte complete with buffer empty (o_valid=0): o_data loaded, o_valid=1 on the next cycle.
REQ-020 Byte complete with o_valid=1 and i_ready=0: new byte dropped, o_data unchanged, o_overrun pulsed one cycle.
REQ-021 Byte complete in the same cycle as acceptance (o_valid&&i_ready): new byte loaded, o_valid stays 1, no overrun.
REQ-022 Acceptance with no completion: o_valid cleared next cycle; o_data may retain old value.
REQ-023 o_data SHALL remain stable while o_valid=1 and not accepted.
REQ-024 Latency: o_valid rises at most 2 cycles after the stop-bit sample edge; end-to-end from start-bit falling edge ~9.5 bit times + synchronizer (2 cycles).

Reset
REQ-025 While i_rst=1: FSM=IDLE, counters=0, shift register=0, synchronizer=1, o_data=0x00, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame without any flag; after release, reception restarts only on a new falling edge.

Verification (CLKS_PER_BIT=16)
REQ-027 Send 0xA5 8N1, i_ready=1 -> single o_valid cycle with o_data=0xA5, o_frame_err=0, o_overrun=0.
REQ-028 Low glitch of 5 cycles on idle line -> FSM returns to IDLE, o_valid stays 0, no flags.
REQ-029 Send 0x3C with stop bit forced 0 -> o_frame_err one pulse, o_valid stays 0; line held low 100 cycles -> no second pulse; then 0x55 -> o_data=0x55.
REQ-030 i_ready=0, send 0x11 then 0x22 -> o_data=0x11 held, o_overrun one pulse on 0x22 completion; raise i_ready -> 0x11 accepted, o_valid=0.
REQ-031 Back-to-back 0x00, 0xFF with i_ready=1 -> o_data 0x00 then 0xFF, no flags.
REQ-032 Assert i_rst during DATA of byte 0x81 -> all outputs reset values, no o_valid; subsequent 0x7E received correctly.
